// File: rtl/seg7_scan_mux.sv
// Time-multiplexed N-digit 7-segment scanner: prescaled slots, anti-ghost blanking,
// per-digit enable mask and per-slot pattern snapshot, all outputs registered.
module seg7_scan_mux #(
  parameter int N_DIG      = 4,
  parameter int SEG_W      = 7,
  parameter int PRESCALE   = 50000,
  parameter int BLANK_CYC  = 2,
  parameter int ACTIVE_LOW = 1,
  localparam int IW        = $clog2(N_DIG)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   en,
  input  logic [N_DIG*SEG_W-1:0] D,
  input  logic [N_DIG-1:0]       dig_en,
  output logic [SEG_W-1:0]       S,
  output logic [N_DIG-1:0]       AN,
  output logic [IW-1:0]          Sel,
  output logic                   frm
);

  // BLANK_CYC=0 still spends one decision cycle dark.
  localparam int BLANK_LEN = (BLANK_CYC > 1) ? BLANK_CYC : 1;
  localparam int BW        = $clog2(BLANK_LEN + 1);
  localparam int PW        = $clog2(PRESCALE + 1);

  localparam logic [SEG_W-1:0] S_DARK  = (ACTIVE_LOW != 0) ? {SEG_W{1'b1}} : '0;
  localparam logic [N_DIG-1:0] AN_DARK = (ACTIVE_LOW != 0) ? {N_DIG{1'b1}} : '0;

  typedef enum logic {BLANK, SHOW} state_e;

  state_e           state_q, state_d;
  logic [BW-1:0]    blank_cnt_q, blank_cnt_d;
  logic [PW-1:0]    presc_cnt_q, presc_cnt_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [IW-1:0]    sel_q, sel_d;
  logic [SEG_W-1:0] seg_q, seg_d;
  logic             live_q, live_d;
  logic [SEG_W-1:0] s_q, s_d;
  logic [N_DIG-1:0] an_q, an_d;
  logic             frm_q, frm_d;

  logic             found;
  logic [IW-1:0]    next_k;

  function automatic logic [SEG_W-1:0] seg_pins(input logic [SEG_W-1:0] pat);
    return (ACTIVE_LOW != 0) ? ~pat : pat;
  endfunction

  function automatic logic [N_DIG-1:0] an_pins(input logic [IW-1:0] k);
    logic [N_DIG-1:0] oh;
    oh    = '0;
    oh[k] = 1'b1;
    return (ACTIVE_LOW != 0) ? ~oh : oh;
  endfunction

  // Round-robin search starting after idx_q; descending loop so the nearest hit wins.
  always_comb begin
    found  = 1'b0;
    next_k = '0;
    for (int j = N_DIG; j >= 1; j--) begin
      if (dig_en[(int'(idx_q) + j) % N_DIG]) begin
        found  = 1'b1;
        next_k = IW'((int'(idx_q) + j) % N_DIG);
      end
    end
  end

  // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d     = state_q;
    blank_cnt_d = blank_cnt_q;
    presc_cnt_d = presc_cnt_q;
    idx_d       = idx_q;
    sel_d       = sel_q;
    seg_d       = seg_q;
    live_d      = live_q;
    s_d         = S_DARK;
    an_d        = AN_DARK;
    frm_d       = 1'b0;

    if (en) begin
      unique case (state_q)
        BLANK: begin
          if (blank_cnt_q != BW'(BLANK_LEN - 1)) begin
            blank_cnt_d = blank_cnt_q + 1'b1;
          end else if (found) begin
            state_d     = SHOW;
            blank_cnt_d = '0;
            presc_cnt_d = '0;
            idx_d       = next_k;
            sel_d       = next_k;
            seg_d       = D[int'(next_k)*SEG_W +: SEG_W];
            live_d      = 1'b1;
            // idx resets to N_DIG-1, so the first slot after reset also flags a frame.
            frm_d       = (next_k <= idx_q);
            s_d         = seg_pins(D[int'(next_k)*SEG_W +: SEG_W]);
            an_d        = an_pins(next_k);
          end
        end
        SHOW: begin
          if (presc_cnt_q == PW'(PRESCALE - 1)) begin
            state_d     = BLANK;
            presc_cnt_d = '0;
          end else begin
            presc_cnt_d = presc_cnt_q + 1'b1;
            // A digit masked mid-slot stays dark until the slot ends, even if re-enabled.
            live_d      = live_q && dig_en[idx_q];
            if (live_d) begin
              s_d  = seg_pins(seg_q);
              an_d = an_pins(idx_q);
            end
          end
        end
        default: state_d = BLANK;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= BLANK;
      blank_cnt_q <= '0;
      presc_cnt_q <= '0;
      idx_q       <= IW'(N_DIG - 1);
      sel_q       <= '0;
      seg_q       <= '0;
      live_q      <= 1'b0;
      s_q         <= S_DARK;
      an_q        <= AN_DARK;
      frm_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      blank_cnt_q <= blank_cnt_d;
      presc_cnt_q <= presc_cnt_d;
      idx_q       <= idx_d;
      sel_q       <= sel_d;
      seg_q       <= seg_d;
      live_q      <= live_d;
      s_q         <= s_d;
      an_q        <= an_d;
      frm_q       <= frm_d;
    end
  end

  assign S   = s_q;
  assign AN  = an_q;
  assign Sel = sel_q;
  assign frm = frm_q;

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Self-checking bench for seg7_scan_mux: directed scenarios plus a randomized phase,
// every cycle compared against a behavioural slot-timing model.
module tb_seg7_scan_mux;

  localparam int ND = 4;
  localparam int SW = 7;
  localparam int PS = 4;
  localparam int BC = 1;
  localparam int BL = (BC > 1) ? BC : 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             en;
  logic [ND*SW-1:0] D;
  logic [ND-1:0]    dig_en;
  logic [SW-1:0]    S;
  logic [ND-1:0]    AN;
  logic [1:0]       Sel;
  logic             frm;

  int total = 0;
  int bad   = 0;

  // Model state: slot phase, cycles spent in it, current digit, snapshot.
  bit         m_show, m_live, m_first;
  int         m_cnt, m_cur;
  logic [6:0] m_snap;
  logic [6:0] m_s;
  logic [3:0] m_an;
  logic [1:0] m_sel;
  logic       m_frm;

  seg7_scan_mux #(
    .N_DIG(ND), .SEG_W(SW), .PRESCALE(PS), .BLANK_CYC(BC), .ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .reset(reset), .en(en), .D(D), .dig_en(dig_en),
    .S(S), .AN(AN), .Sel(Sel), .frm(frm)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    if (reset) begin
      m_show = 0; m_cnt = 0; m_cur = ND - 1; m_first = 1; m_live = 0;
      m_s = 7'h7F; m_an = 4'hF; m_sel = 2'd0; m_frm = 1'b0;
      return;
    end
    m_frm = 1'b0;
    m_s   = 7'h7F;
    m_an  = 4'hF;
    if (!en) return;
    if (!m_show) begin
      m_cnt++;
      if (m_cnt >= BL) begin
        int k;
        k = -1;
        for (int j = ND; j >= 1; j--)
          if (dig_en[(m_cur + j) % ND]) k = (m_cur + j) % ND;
        if (k < 0) begin
          m_cnt = BL - 1;
        end else begin
          m_frm   = m_first || (k <= m_cur);
          m_first = 0;
          m_cur   = k;
          m_sel   = 2'(k);
          m_snap  = D[k*SW +: SW];
          m_show  = 1;
          m_live  = 1;
          m_cnt   = 1;
          m_s     = ~m_snap;
          m_an    = ~(4'b0001 << k);
        end
      end
    end else if (m_cnt == PS) begin
      m_show = 0;
      m_cnt  = 0;
    end else begin
      m_cnt++;
      m_live = m_live && dig_en[m_cur];
      if (m_live) begin
        m_s  = ~m_snap;
        m_an = ~(4'b0001 << m_cur);
      end
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      check("model_S", S, m_s);
      check("model_AN", AN, m_an);
      check("model_Sel", Sel, m_sel);
      check("model_frm", frm, m_frm);
    end
  endtask

  initial begin
    reset  = 1'b1;
    en     = 1'b1;
    dig_en = 4'hF;
    D      = {7'h4F, 7'h5B, 7'h06, 7'h3F};
    tick(2);
    reset = 1'b0;
    check("rst_an", AN, 4'hF);
    check("rst_s", S, 7'h7F);
    check("rst_sel", Sel, 2'd0);
    check("rst_frm", frm, 1'b0);

    // Full scan with wrap
    tick();  check("s1_an0", AN, 4'b1110); check("s1_s0", S, 7'h40); check("s1_frm0", frm, 1'b1);
    tick(4); check("s1_blank", AN, 4'hF);
    tick();  check("s1_an1", AN, 4'b1101); check("s1_s1", S, 7'h79); check("s1_frm1", frm, 1'b0);
    tick(5); check("s1_an2", AN, 4'b1011); check("s1_s2", S, 7'h24);
    tick(5); check("s1_an3", AN, 4'b0111); check("s1_s3", S, 7'h30); check("s1_frm3", frm, 1'b0);
    tick(5); check("s1_wrap", AN, 4'b1110); check("s1_wrap_frm", frm, 1'b1);

    // Snapshot holds through a mid-slot data change
    D[6:0] = 7'h7F;
    tick();   check("s3_hold", S, 7'h40);
    tick(2);  check("s3_hold_end", S, 7'h40); check("s3_hold_an", AN, 4'b1110);
    tick(17); check("s3_new", S, 7'h00); check("s3_new_an", AN, 4'b1110);

    // Sparse mask 0101
    dig_en = 4'b0101;
    tick(5); check("s2_sel2", Sel, 2'd2); check("s2_an2", AN, 4'b1011); check("s2_frm2", frm, 1'b0);
    tick(5); check("s2_sel0", Sel, 2'd0); check("s2_frm0", frm, 1'b1);
    tick(5); check("s2_sel2b", Sel, 2'd2);
    tick(5); check("s2_sel0b", Sel, 2'd0); check("s2_frm0b", frm, 1'b1);

    // Mask cleared mid-slot: dark for the rest of the slot even if restored
    dig_en = 4'b0100;
    tick(); check("mask_dark", AN, 4'hF);
    dig_en = 4'b0101;
    tick(); check("mask_stay_dark", AN, 4'hF);
    tick(3); check("mask_next", AN, 4'b1011); check("mask_next_sel", Sel, 2'd2);
    tick(5); check("mask_back", AN, 4'b1110); check("mask_back_frm", frm, 1'b1);

    // No digit enabled, then a single digit
    reset = 1'b1;
    tick(2);
    dig_en = 4'h0;
    reset  = 1'b0;
    tick(10); check("s4_dark_an", AN, 4'hF); check("s4_dark_s", S, 7'h7F);
    dig_en = 4'b1000;
    tick();  check("s4_sel3", Sel, 2'd3); check("s4_an3", AN, 4'b0111);
    check("s4_frm", frm, 1'b1); check("s4_s3", S, 7'h30);
    tick(5); check("s4_relit", AN, 4'b0111); check("s4_relit_frm", frm, 1'b1);

    // Scan freeze mid-slot
    dig_en = 4'hF;
    tick();   check("s5_pre", AN, 4'b0111);
    en = 1'b0;
    tick(10); check("s5_frozen_an", AN, 4'hF); check("s5_frozen_s", S, 7'h7F);
    en = 1'b1;
    tick(); check("s5_res1", AN, 4'b0111); check("s5_res1_s", S, 7'h30);
    tick(); check("s5_res2", AN, 4'b0111);
    tick(); check("s5_end", AN, 4'hF);
    tick(); check("s5_next", AN, 4'b1110); check("s5_next_frm", frm, 1'b1);

    // Reset during digit 2
    for (int i = 0; i < 40 && AN !== 4'b1011; i++) tick();
    check("s6_reach", AN, 4'b1011);
    tick();
    reset = 1'b1;
    tick(); check("s6_an", AN, 4'hF); check("s6_sel", Sel, 2'd0); check("s6_frm", frm, 1'b0);
    reset = 1'b0;
    tick(); check("s6_restart", AN, 4'b1110); check("s6_restart_frm", frm, 1'b1);

    // Randomized traffic
    for (int c = 0; c < 800; c++) begin
      reset = ($urandom_range(0, 99) == 0);
      en    = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 14) == 0) dig_en = 4'($urandom);
      if ($urandom_range(0, 3) == 0)  D = 28'($urandom);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
